// File: rtl/tlul_pkg.sv
// ============================================================================
//  Module      : tlul_pkg
//  Description : TL-UL channel types shared by the bus fabric, plus the
//                response-mode enum and request-FIFO entry used by the
//                terminal responder (tlul_resp_gen).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tlul_pkg;

    localparam int TL_AW  = 32;  // address width
    localparam int TL_DW  = 32;  // data width
    localparam int TL_AIW = 8;   // A-channel source id width
    localparam int TL_DIW = 1;   // D-channel sink id width
    localparam int TL_SZW = 2;   // size field width
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_DUW = 4;   // D-channel user width

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    // Host -> device: A channel plus the D-channel ready.
    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    // Device -> host: D channel plus the A-channel ready.
    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic [TL_DUW-1:0]   d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    typedef enum logic [1:0] {
        RESP_SUCCESS    = 2'd0,
        RESP_ERROR      = 2'd1,
        RESP_FROM_INPUT = 2'd2
    } tl_resp_mode_e;

    // One outstanding request; err is resolved when the request is accepted.
    typedef struct packed {
        logic [TL_AIW-1:0]   source;
        logic [TL_SZW-1:0]   size;
        tl_a_op_e            opcode;
        logic                err;
    } tl_resp_entry_t;

endpackage

`default_nettype wire

// File: rtl/tlul_resp_fifo.sv
// ============================================================================
//  Module      : tlul_resp_fifo
//  Description : Generic synchronous FIFO holding Depth entries of ENTRY_T.
//                Depth need not be a power of two; pointers wrap explicitly.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                push, push_data - write request (ignored while full)
//                pop           - read request (ignored while empty)
//                full, empty, count - occupancy, all from registered state
//                head          - oldest entry (valid while !empty)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlul_resp_fifo #(
    parameter  int unsigned Depth   = 2,
    parameter  type         ENTRY_T = logic,
    localparam int unsigned PTR_W   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CNT_W   = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  ENTRY_T           push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output ENTRY_T           head
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(Depth - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Depth);

    ENTRY_T           mem [Depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tlul_resp_gen.sv
// ============================================================================
//  Module      : tlul_resp_gen
//  Description : TL-UL terminal responder. Every accepted A-channel request
//                is completed locally with an in-order D-channel response.
//                Serves as the sink for IOPMP-denied traffic and as the
//                default slave for unmapped address space.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                req_i    - TL-UL host request (A channel, d_ready)
//                err_i    - per-request error flag (RESP_FROM_INPUT only)
//                rsp_o    - TL-UL device response (D channel, a_ready)
//                busy_o   - at least one response outstanding
//                rsp_cnt_o, err_cnt_o - saturating response / error
//                           counters, present only with
//                           TLUL_RESP_GEN_STATS_EN defined
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlul_resp_gen
    import tlul_pkg::*;
#(
    parameter int unsigned       Depth    = 2,
    parameter tl_resp_mode_e     RespMode = RESP_SUCCESS,
    parameter logic [TL_DW-1:0]  RespData = 32'hFFFF_FFFF,
    parameter logic [TL_DW-1:0]  ErrData  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  tl_h2d_t     req_i,
    input  logic        err_i,
    output tl_d2h_t     rsp_o,
    output logic        busy_o
`ifdef TLUL_RESP_GEN_STATS_EN
    ,
    output logic [15:0] rsp_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(Depth + 1);

    tl_resp_entry_t   push_entry;
    tl_resp_entry_t   head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] fifo_count;
    logic             a_fire;
    logic             d_fire;
    logic             entry_err;

    // a_ready comes straight from the registered occupancy, so neither
    // d_ready nor a_valid can reach it combinationally.
    assign a_fire = req_i.a_valid && !full;
    assign d_fire = !empty && req_i.d_ready;

    always_comb begin
        entry_err = 1'b0;
        case (RespMode)
            RESP_ERROR:      entry_err = 1'b1;
            RESP_FROM_INPUT: entry_err = err_i;
            default:         entry_err = 1'b0;
        endcase
    end

    assign push_entry = '{source: req_i.a_source,
                          size:   req_i.a_size,
                          opcode: req_i.a_opcode,
                          err:    entry_err};

    tlul_resp_fifo #(
        .Depth   (Depth),
        .ENTRY_T (tl_resp_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (a_fire),
        .push_data (push_entry),
        .pop       (d_fire),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count),
        .head      (head)
    );

    // D fields are forced to zero while nothing is pending so that stale
    // storage never shows on the bus. Unknown opcodes are acked as writes.
    always_comb begin
        rsp_o         = '0;
        rsp_o.a_ready = !full;
        if (!empty) begin
            rsp_o.d_valid  = 1'b1;
            rsp_o.d_size   = head.size;
            rsp_o.d_source = head.source;
            rsp_o.d_error  = head.err;
            if (head.opcode == Get) begin
                rsp_o.d_opcode = AccessAckData;
                rsp_o.d_data   = head.err ? ErrData : RespData;
            end else begin
                rsp_o.d_opcode = AccessAck;
            end
        end
    end

    assign busy_o = (fifo_count != '0);

`ifdef TLUL_RESP_GEN_STATS_EN
    logic [15:0] rsp_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (d_fire) begin
            if (rsp_cnt_q != 16'hFFFF) begin
                rsp_cnt_q <= rsp_cnt_q + 16'd1;
            end
            if (head.err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign rsp_cnt_o = rsp_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

    // Request payload is never stored; a terminal responder discards it.
    logic unused_inputs;
    assign unused_inputs = ^{req_i.a_param, req_i.a_address,
                             req_i.a_mask, req_i.a_data, err_i};

endmodule

`default_nettype wire

// File: tb/tb_tlul_resp_gen.sv
// ============================================================================
//  Module      : tb_tlul_resp_gen
//  Description : Self-checking bench for tlul_resp_gen. Three instances:
//                  0: Depth=2, RESP_SUCCESS (default data)
//                  1: Depth=2, RESP_FROM_INPUT (distinct Resp/Err data)
//                  2: Depth=3, RESP_ERROR (distinct Resp/Err data)
//                Expected responses are queued on A handshakes and compared
//                against the D channel while d_valid is high.
//                Stats checks are compiled with TLUL_RESP_GEN_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tlul_resp_gen;
    import tlul_pkg::*;

    typedef struct packed {
        logic [TL_AIW-1:0] src;
        logic [TL_SZW-1:0] size;
        logic              err;
        tl_d_op_e          op;
        logic [TL_DW-1:0]  data;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t req    [3];
    tl_d2h_t rsp    [3];
    logic    err_in [3];
    logic    busy   [3];
    logic [15:0] rc [3];
    logic [15:0] ec [3];

    always #5 clk = ~clk;

    int            depth_m [3] = '{2, 2, 3};
    tl_resp_mode_e mode_m  [3] = '{RESP_SUCCESS, RESP_FROM_INPUT, RESP_ERROR};
    logic [31:0]   respd_m [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0A5A_5A5A};
    logic [31:0]   errd_m  [3] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hBAD0_0BAD};
    int            cnt_m   [3];
    bit            fire_a  [3];
    logic [15:0]   rsp_m;
    logic [15:0]   err_m;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;

    tlul_resp_gen #(.Depth(2), .RespMode(RESP_SUCCESS)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .err_i(err_in[0]),
        .rsp_o(rsp[0]), .busy_o(busy[0])
`ifdef TLUL_RESP_GEN_STATS_EN
        , .rsp_cnt_o(rc[0]), .err_cnt_o(ec[0])
`endif
    );

    tlul_resp_gen #(.Depth(2), .RespMode(RESP_FROM_INPUT),
                    .RespData(32'h1234_5678), .ErrData(32'hDEAD_BEEF)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .err_i(err_in[1]),
        .rsp_o(rsp[1]), .busy_o(busy[1])
`ifdef TLUL_RESP_GEN_STATS_EN
        , .rsp_cnt_o(rc[1]), .err_cnt_o(ec[1])
`endif
    );

    tlul_resp_gen #(.Depth(3), .RespMode(RESP_ERROR),
                    .RespData(32'h0A5A_5A5A), .ErrData(32'hBAD0_0BAD)) u_dut2 (
        .clk(clk), .rst(rst), .req_i(req[2]), .err_i(err_in[2]),
        .rsp_o(rsp[2]), .busy_o(busy[2])
`ifdef TLUL_RESP_GEN_STATS_EN
        , .rsp_cnt_o(rc[2]), .err_cnt_o(ec[2])
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qpush(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic set_a(input int i, input logic v, input tl_a_op_e op,
                         input logic [7:0] src, input logic [1:0] sz);
        req[i].a_valid   = v;
        req[i].a_opcode  = op;
        req[i].a_source  = src;
        req[i].a_size    = sz;
        req[i].a_address = 32'h4000_0000 | {24'd0, src};
        req[i].a_data    = {4{src}};
        req[i].a_mask    = 4'hF;
    endtask

    // Check every instance against the model, account handshakes, advance.
    task automatic step();
        #1;
        for (int i = 0; i < 3; i++) begin
            logic fa, fd;
            exp_t h, e;
            chk($sformatf("a_ready%0d", i), rsp[i].a_ready, cnt_m[i] != depth_m[i]);
            chk($sformatf("d_valid%0d", i), rsp[i].d_valid, cnt_m[i] != 0);
            chk($sformatf("busy%0d", i), busy[i], cnt_m[i] != 0);
            fa = req[i].a_valid && rsp[i].a_ready;
            fd = rsp[i].d_valid && req[i].d_ready;
            if (rsp[i].d_valid && qsize(i) > 0) begin
                h = qfront(i);
                chk($sformatf("d_source%0d", i), rsp[i].d_source, h.src);
                chk($sformatf("d_size%0d", i), rsp[i].d_size, h.size);
                chk($sformatf("d_opcode%0d", i), rsp[i].d_opcode, h.op);
                chk($sformatf("d_error%0d", i), rsp[i].d_error, h.err);
                chk($sformatf("d_data%0d", i), rsp[i].d_data, h.data);
                chk($sformatf("d_zero%0d", i),
                    {rsp[i].d_param, rsp[i].d_sink, rsp[i].d_user}, 0);
                if (fd) begin
                    qpop(i);
                    if (i == 2) begin
                        if (rsp_m != 16'hFFFF) rsp_m = rsp_m + 16'd1;
                        if (h.err && err_m != 16'hFFFF) err_m = err_m + 16'd1;
                    end
                end
            end
            if (fa) begin
                e.src  = req[i].a_source;
                e.size = req[i].a_size;
                case (mode_m[i])
                    RESP_SUCCESS: e.err = 1'b0;
                    RESP_ERROR:   e.err = 1'b1;
                    default:      e.err = err_in[i];
                endcase
                e.op   = (req[i].a_opcode == Get) ? AccessAckData : AccessAck;
                e.data = (e.op == AccessAckData) ? (e.err ? errd_m[i] : respd_m[i]) : '0;
                qpush(i, e);
            end
            cnt_m[i]  = cnt_m[i] + (fa ? 1 : 0) - (fd ? 1 : 0);
            fire_a[i] = fa;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); q2.delete();
        for (int i = 0; i < 3; i++) cnt_m[i] = 0;
        rsp_m = '0;
        err_m = '0;
    endtask

    initial begin
        tl_d2h_t idle_rsp;
        idle_rsp         = '0;
        idle_rsp.a_ready = 1'b1;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i]    = '0;
            err_in[i] = 1'b0;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_rsp%0d", i), rsp[i], idle_rsp);
            chk($sformatf("reset_busy%0d", i), busy[i], 1'b0);
        end
`ifdef TLUL_RESP_GEN_STATS_EN
        chk("reset_rsp_cnt", rc[2], 16'd0);
        chk("reset_err_cnt", ec[2], 16'd0);
`endif

        // 1: single Get, one-cycle latency, response gone the cycle after.
        req[0].d_ready = 1'b1;
        set_a(0, 1'b1, Get, 8'd5, 2'd2);
        step();
        set_a(0, 1'b0, Get, 8'd0, 2'd0);
        step();
        step();

        // 2: fill Depth=2 with d_ready low, third waits for the first pop.
        req[0].d_ready = 1'b0;
        set_a(0, 1'b1, PutFullData, 8'd1, 2'd2);
        step();
        set_a(0, 1'b1, PutFullData, 8'd2, 2'd2);
        step();
        set_a(0, 1'b1, PutFullData, 8'd3, 2'd2);
        step();
        chk("t2_blocked", fire_a[0], 1'b0);
        step();
        chk("t2_still_blocked", fire_a[0], 1'b0);
        req[0].d_ready = 1'b1;
        step();
        chk("t2_no_accept_on_pop", fire_a[0], 1'b0);
        step();
        chk("t2_third_accept", fire_a[0], 1'b1);
        set_a(0, 1'b0, Get, 8'd0, 2'd0);
        step();
        step();

        // 3: per-request error flag.
        req[1].d_ready = 1'b1;
        err_in[1] = 1'b1;
        set_a(1, 1'b1, Get, 8'd7, 2'd1);
        step();
        err_in[1] = 1'b0;
        set_a(1, 1'b1, Get, 8'd8, 2'd3);
        step();
        set_a(1, 1'b0, Get, 8'd0, 2'd0);
        step();
        step();

        // 4: Depth=3 streaming, mixed opcodes including an unknown one.
        req[2].d_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tl_a_op_e op;
            case (k % 3)
                0:       op = Get;
                1:       op = PutPartialData;
                default: op = tl_a_op_e'(3'h2);
            endcase
            set_a(2, 1'b1, op, 8'(16 + k), 2'(k % 4));
            step();
            chk("t4_count_le1", u_dut2.fifo_count <= 2'd1, 1'b1);
        end
        set_a(2, 1'b0, Get, 8'd0, 2'd0);
        step();
        step();

        // 5: reset with two responses pending discards them.
        req[0].d_ready = 1'b0;
        set_a(0, 1'b1, PutFullData, 8'd9, 2'd0);
        step();
        set_a(0, 1'b1, Get, 8'd10, 2'd1);
        step();
        set_a(0, 1'b0, Get, 8'd0, 2'd0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_model();
        #1;
        chk("t5_d_valid", rsp[0].d_valid, 1'b0);
        chk("t5_a_ready", rsp[0].a_ready, 1'b1);
        chk("t5_busy", busy[0], 1'b0);
        req[0].d_ready = 1'b1;
        repeat (3) step();

`ifdef TLUL_RESP_GEN_STATS_EN
        // 6: counters on the RESP_ERROR instance, then saturation.
        for (int k = 0; k < 4; k++) begin
            set_a(2, 1'b1, Get, 8'(32 + k), 2'd2);
            step();
        end
        set_a(2, 1'b0, Get, 8'd0, 2'd0);
        step();
        step();
        chk("t6_rsp_cnt", rc[2], rsp_m);
        chk("t6_err_cnt", ec[2], err_m);
        chk("t6_rsp_cnt4", rc[2], 16'd4);
        force u_dut2.rsp_cnt_q = 16'hFFFF;
        @(posedge clk);
        #2;
        release u_dut2.rsp_cnt_q;
        rsp_m = 16'hFFFF;
        set_a(2, 1'b1, PutFullData, 8'd40, 2'd0);
        step();
        set_a(2, 1'b0, Get, 8'd0, 2'd0);
        step();
        step();
        chk("t6_rsp_sat", rc[2], 16'hFFFF);
        chk("t6_err_cnt5", ec[2], err_m);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tlul_resp_gen.md
Name: tlul_resp_gen

Overview:
Parametrised TL-UL terminal responder that completes every accepted A-channel request locally, with a D-channel response from a request FIFO.
- Supports up to Depth outstanding requests; responses return in order.
- Per-request success or error, selected by RespMode (fixed success, fixed error, or the per-request err_i flag from the IOPMP decision path).
- Used as the sink for IOPMP-denied traffic and as a default slave for unmapped address space.

Parameters:
Depth, 2, number of outstanding requests buffered (>=1, any integer, not restricted to powers of two)
RespMode, RESP_SUCCESS, tlul_pkg::tl_resp_mode_e: RESP_SUCCESS, RESP_ERROR, RESP_FROM_INPUT
RespData, 32'hFFFF_FFFF, d_data returned for successful Get
ErrData, 32'hFFFF_FFFF, d_data returned for erroneous Get

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_i  in  tlul_pkg::tl_h2d_t  TL-UL host request (A channel, d_ready)
err_i  in  1  per-request error flag, sampled with the A handshake; used only when RespMode==RESP_FROM_INPUT
rsp_o  out  tlul_pkg::tl_d2h_t  TL-UL device response (D channel, a_ready)
busy_o  out  1  at least one response outstanding

Behaviour:
- Accept condition: A fire = req_i.a_valid && rsp_o.a_ready.
- a_ready = ~full. Depends only on the registered count. No combinational path from d_ready to a_ready.
- Pop condition: D fire = rsp_o.d_valid && req_i.d_ready.
- On A fire, push entry {source=a_source, size=a_size, opcode=a_opcode, err}.
- err is resolved at push time:
  - RESP_SUCCESS -> 0
  - RESP_ERROR -> 1
  - RESP_FROM_INPUT -> err_i
- Latency: d_valid asserts on the cycle after A fire, earliest. No combinational A->D path.
- d_valid = ~empty. D fields come from the head entry and are held stable while d_valid && !d_ready.
- D field mapping:
  - d_opcode = AccessAckData if head.opcode==Get, else AccessAck.
  - d_size = head.size. Size is echoed, not zeroed.
  - d_source = head.source.
  - d_sink = 0; d_param = 0; d_user = 0.
  - d_error = head.err.
  - d_data: for AccessAckData, ErrData if err, else RespData. For AccessAck, 0.
- Pointers: wr_ptr and rd_ptr run 0..Depth-1 and wrap explicitly to 0 after Depth-1. count runs 0..Depth.
- Full: a_ready=0, no push.
- Empty: d_valid=0, no pop.
- Simultaneous push and pop (not full): both pointers advance and count is unchanged.
- Simultaneous push and pop at count==Depth: impossible by construction, because a_ready=0 while full.
- Opcodes other than Get/PutFullData/PutPartialData are treated as writes (AccessAck).
- Reset:
  - Pointers, count, and stats counters go to 0.
  - Outputs: a_ready=1, d_valid=0, busy_o=0, all D fields 0.
  - Reset mid-operation discards all outstanding entries without issuing responses.
  - Reset dominates any simultaneous handshake.
- busy_o = (count != 0).

Optional Feature:
Macro TLUL_RESP_GEN_STATS_EN.
- With the macro defined:
  - Adds output ports rsp_cnt_o[15:0] and err_cnt_o[15:0].
  - rsp_cnt_o increments on each D fire.
  - err_cnt_o increments on each D fire with d_error=1.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- tlul_pkg gains:
  - tl_resp_mode_e enum
  - tl_resp_entry_t packed struct {source[TL_AIW], size[TL_SZW], opcode tl_a_op_e, err}
- Sub-module tlul_resp_fifo: generic sync FIFO with parameters Depth and entry type.
  - Ports: push/pop/full/empty/count/head.
  - Instantiated once.
- D-field mapping stays combinational in tlul_resp_gen.

Test Plan:
1. RESP_SUCCESS, Depth=2. Get with source=5, size=2, d_ready=1 -> next cycle d_valid=1, AccessAckData, d_source=5, d_size=2, d_data=FFFF_FFFF, d_error=0. Next cycle d_valid=0.
2. Depth=2, d_ready=0. Issue 3 back-to-back PutFullData with sources 1,2,3 -> first two accepted and a_ready=0 after the second. Raise d_ready -> AccessAck for sources 1,2 in order. Third accepted the cycle after the first pop.
3. RESP_FROM_INPUT. Get with err_i=1 then Get with err_i=0 -> first response d_error=1 with ErrData; second d_error=0 with RespData.
4. Depth=3. Continuous push and pop for 10 requests with d_ready=1 -> sources returned in order, pointer wrap at index 2 correct, count never exceeds 1.
5. Two entries pending, assert rst for 1 cycle -> next cycle d_valid=0, a_ready=1, busy_o=0. No stale response follows.
6. With TLUL_RESP_GEN_STATS_EN and RESP_ERROR, 4 responses -> rsp_cnt_o=4, err_cnt_o=4. Preload rsp_cnt_o to FFFF by forcing -> stays FFFF after another response.
